// File: rtl/cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : cmd_arb
// Brief    : Two-source command arbiter with STOP precedence, round-robin
//            tie-break and an acknowledge timeout for the command processor.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_arb #(
    parameter int TIMEOUT  = 1024,
    parameter int STOP_PRI = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy0,
    input  logic [7:0] cmd0,
    output logic       clr_rdy0,
    input  logic       rdy1,
    input  logic [7:0] cmd1,
    output logic       clr_rdy1,
    output logic       cmd_rdy,
    output logic [7:0] cmd,
    input  logic       clr_cmd_rdy,
    output logic [1:0] gnt,
    output logic       timeout_err
);

    localparam int            TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        r_state, w_state_nx;
    logic [TW-1:0] r_timer, w_timer_nx;
    logic          r_rr, w_rr_nx;
    logic [7:0]    w_cmd_nx;
    logic [1:0]    w_gnt_nx;
    logic          w_cmd_rdy_nx, w_clr0_nx, w_clr1_nx, w_terr_nx;
    logic          w_stop0, w_stop1, w_win1;

    assign w_stop0 = (cmd0[7:6] == 2'b00);
    assign w_stop1 = (cmd1[7:6] == 2'b00);

    // A single STOP among two contenders wins; otherwise rr picks the source.
    always_comb begin
        if (rdy0 && !rdy1)
            w_win1 = 1'b0;
        else if (!rdy0 && rdy1)
            w_win1 = 1'b1;
        else if ((STOP_PRI != 0) && (w_stop0 != w_stop1))
            w_win1 = w_stop1;
        else
            w_win1 = r_rr;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_timer_nx   = r_timer;
        w_rr_nx      = r_rr;
        w_cmd_nx     = cmd;
        w_gnt_nx     = gnt;
        w_cmd_rdy_nx = cmd_rdy;
        w_clr0_nx    = 1'b0;
        w_clr1_nx    = 1'b0;
        w_terr_nx    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rdy0 || rdy1) begin
                    w_cmd_nx     = w_win1 ? cmd1 : cmd0;
                    w_gnt_nx     = w_win1 ? 2'b10 : 2'b01;
                    w_cmd_rdy_nx = 1'b1;
                    w_timer_nx   = '0;
                    w_state_nx   = PRESENT;
                end
            end
            PRESENT: begin
                if (r_timer != TLAST)
                    w_timer_nx = r_timer + 1'b1;
                if (clr_cmd_rdy || (r_timer == TLAST)) begin
                    w_cmd_rdy_nx = 1'b0;
                    w_clr0_nx    = gnt[0];
                    w_clr1_nx    = gnt[1];
                    w_terr_nx    = !clr_cmd_rdy;
                    w_state_nx   = RELEASE;
                end
            end
            RELEASE: begin
                w_gnt_nx   = 2'b00;
                w_rr_nx    = gnt[0];
                w_state_nx = IDLE;
            end
            default: begin
                w_gnt_nx     = 2'b00;
                w_cmd_rdy_nx = 1'b0;
                w_state_nx   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_rr        <= 1'b0;
            cmd         <= 8'h00;
            gnt         <= 2'b00;
            cmd_rdy     <= 1'b0;
            clr_rdy0    <= 1'b0;
            clr_rdy1    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_timer     <= w_timer_nx;
            r_rr        <= w_rr_nx;
            cmd         <= w_cmd_nx;
            gnt         <= w_gnt_nx;
            cmd_rdy     <= w_cmd_rdy_nx;
            clr_rdy0    <= w_clr0_nx;
            clr_rdy1    <= w_clr1_nx;
            timeout_err <= w_terr_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_arb
// Brief    : Vector-table and directed-sequence bench for cmd_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy0 = 1'b0, rdy1 = 1'b0, clr_cmd_rdy = 1'b0;
    logic [7:0] cmd0 = 8'h00, cmd1 = 8'h00;

    logic       clr_rdy0, clr_rdy1, cmd_rdy, timeout_err;
    logic [7:0] cmd;
    logic [1:0] gnt;
    logic       np_clr_rdy0, np_clr_rdy1, np_cmd_rdy, np_timeout_err;
    logic [7:0] np_cmd;
    logic [1:0] np_gnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cmd_arb #(.TIMEOUT(8), .STOP_PRI(1)) dut (
        .clk(clk), .rst(rst),
        .rdy0(rdy0), .cmd0(cmd0), .clr_rdy0(clr_rdy0),
        .rdy1(rdy1), .cmd1(cmd1), .clr_rdy1(clr_rdy1),
        .cmd_rdy(cmd_rdy), .cmd(cmd), .clr_cmd_rdy(clr_cmd_rdy),
        .gnt(gnt), .timeout_err(timeout_err)
    );

    cmd_arb #(.TIMEOUT(8), .STOP_PRI(0)) dut_np (
        .clk(clk), .rst(rst),
        .rdy0(rdy0), .cmd0(cmd0), .clr_rdy0(np_clr_rdy0),
        .rdy1(rdy1), .cmd1(cmd1), .clr_rdy1(np_clr_rdy1),
        .cmd_rdy(np_cmd_rdy), .cmd(np_cmd), .clr_cmd_rdy(clr_cmd_rdy),
        .gnt(np_gnt), .timeout_err(np_timeout_err)
    );

    typedef struct packed {
        logic       r0;
        logic [7:0] c0;
        logic       r1;
        logic [7:0] c1;
        logic       ack;
        logic       e_rdy;
        logic [7:0] e_cmd;
        logic [1:0] e_gnt;
        logic       e_clr0;
        logic       e_clr1;
        logic       e_to;
        logic [1:0] e_ngnt;
        logic [7:0] e_ncmd;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy0 = 1'b0; rdy1 = 1'b0; clr_cmd_rdy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        //            r0 c0     r1 c1     ack rdy cmd    gnt   c0 c1 to  ngnt  ncmd
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00};
        vecs[1]  = '{1'b1, 8'h75, 1'b1, 8'h8F, 1'b0, 1'b1, 8'h75, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h75};
        vecs[2]  = '{1'b1, 8'h75, 1'b1, 8'h8F, 1'b1, 1'b0, 8'h75, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 8'h75};
        vecs[3]  = '{1'b1, 8'h75, 1'b1, 8'h8F, 1'b0, 1'b0, 8'h75, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h75};
        vecs[4]  = '{1'b1, 8'h75, 1'b1, 8'h8F, 1'b0, 1'b1, 8'h8F, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10, 8'h8F};
        vecs[5]  = '{1'b1, 8'h75, 1'b1, 8'h8F, 1'b1, 1'b0, 8'h8F, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, 8'h8F};
        vecs[6]  = '{1'b1, 8'h75, 1'b1, 8'h8F, 1'b0, 1'b0, 8'h8F, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h8F};
        vecs[7]  = '{1'b1, 8'h75, 1'b1, 8'h8F, 1'b0, 1'b1, 8'h75, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 8'h75};
        vecs[8]  = '{1'b1, 8'h75, 1'b1, 8'h8F, 1'b1, 1'b0, 8'h75, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 8'h75};
        vecs[9]  = '{1'b1, 8'h75, 1'b1, 8'h8F, 1'b0, 1'b0, 8'h75, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h75};
        vecs[10] = '{1'b1, 8'h75, 1'b1, 8'h8F, 1'b0, 1'b1, 8'h8F, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10, 8'h8F};
        vecs[11] = '{1'b1, 8'h75, 1'b1, 8'h8F, 1'b1, 1'b0, 8'h8F, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, 8'h8F};
        vecs[12] = '{1'b0, 8'h75, 1'b0, 8'h8F, 1'b0, 1'b0, 8'h8F, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h8F};
        // rr back at source 0: the STOP on source 1 must jump ahead only with STOP_PRI=1
        vecs[13] = '{1'b1, 8'h75, 1'b1, 8'h0D, 1'b0, 1'b1, 8'h0D, 2'b10, 1'b0, 1'b0, 1'b0, 2'b01, 8'h75};

        tick();
        tick();
        rst = 1'b0;
        chk("reset cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("reset cmd", 32'(cmd), 32'h00);
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset pulses", {29'd0, clr_rdy0, clr_rdy1, timeout_err}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            rdy0 = vecs[i].r0; cmd0 = vecs[i].c0;
            rdy1 = vecs[i].r1; cmd1 = vecs[i].c1;
            clr_cmd_rdy = vecs[i].ack;
            tick();
            chk($sformatf("v%0d cmd_rdy", i), 32'(cmd_rdy), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d cmd", i), 32'(cmd), 32'(vecs[i].e_cmd));
            chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d clr_rdy0", i), 32'(clr_rdy0), 32'(vecs[i].e_clr0));
            chk($sformatf("v%0d clr_rdy1", i), 32'(clr_rdy1), 32'(vecs[i].e_clr1));
            chk($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'(vecs[i].e_to));
            chk($sformatf("v%0d np gnt", i), 32'(np_gnt), 32'(vecs[i].e_ngnt));
            chk($sformatf("v%0d np cmd", i), 32'(np_cmd), 32'(vecs[i].e_ncmd));
        end

        // Timeout with no acknowledge: cmd_rdy high exactly 8 cycles
        do_reset();
        rdy0 = 1'b1; cmd0 = 8'h42;
        tick();
        cnt = 0;
        while (cmd_rdy && cnt < 50) begin
            cnt++;
            tick();
        end
        chk("timeout cmd_rdy cycles", 32'(cnt), 32'd8);
        chk("timeout err pulse", 32'(timeout_err), 32'd1);
        chk("timeout clr_rdy0", 32'(clr_rdy0), 32'd1);
        rdy0 = 1'b0;
        tick();
        chk("timeout err cleared", {30'd0, timeout_err, clr_rdy0}, 32'd0);
        chk("timeout gnt idle", 32'(gnt), 32'd0);

        // Acknowledge on the last permitted cycle beats the timeout
        do_reset();
        rdy0 = 1'b1; cmd0 = 8'h42;
        tick();
        rdy0 = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("ack8 still presented", 32'(cmd_rdy), 32'd1);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        chk("ack8 no timeout_err", 32'(timeout_err), 32'd0);
        chk("ack8 clr_rdy0", 32'(clr_rdy0), 32'd1);
        chk("ack8 cmd_rdy low", 32'(cmd_rdy), 32'd0);

        // Source withdraws after being latched
        do_reset();
        rdy1 = 1'b1; cmd1 = 8'h33;
        tick();
        chk("withdraw grant", {22'd0, gnt, cmd}, {22'd0, 2'b10, 8'h33});
        rdy1 = 1'b0; cmd1 = 8'hAA;
        for (int k = 0; k < 3; k++) tick();
        chk("withdraw cmd held", 32'(cmd), 32'h33);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        chk("withdraw clr_rdy1", 32'(clr_rdy1), 32'd1);
        chk("withdraw cmd after ack", 32'(cmd), 32'h33);

        // Reset mid-PRESENT after rr had moved to source 1
        do_reset();
        rdy0 = 1'b1; cmd0 = 8'h75;
        tick();
        clr_cmd_rdy = 1'b1;
        tick();
        rdy0 = 1'b0; clr_cmd_rdy = 1'b0;
        tick();
        rdy1 = 1'b1; cmd1 = 8'h8F;
        tick();
        chk("pre-reset grant src1", 32'(gnt), 32'b10);
        #2 rst = 1'b1;
        #1;
        chk("async reset cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("async reset gnt", 32'(gnt), 32'd0);
        chk("async reset cmd", 32'(cmd), 32'h00);
        tick();
        rst = 1'b0;
        rdy0 = 1'b1; cmd0 = 8'h75;
        tick();
        chk("post-reset rr src0", {22'd0, gnt, cmd}, {22'd0, 2'b01, 8'h75});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_arb.md
Name: cmd_arb

Overview:
- Two-source command arbiter in front of the command processor's single cmd/cmd_rdy/clr_cmd_rdy interface.
- Shares that interface between the wireless UART receiver (source 0) and the local debug console receiver (source 1).
- Latches one command at a time and presents it until the command processor acknowledges it.
- Gives STOP commands precedence, round-robins all other ties, and recovers from a command processor that never acknowledges.

Parameters:
- TIMEOUT, 1024: cycles a command may be presented without clr_cmd_rdy before being dropped (>=2).
- STOP_PRI, 1: 1 = a STOP opcode (cmd[7:6]==2'b00) beats round-robin on a tie; 0 = pure round-robin.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rdy0  in  1  source 0 has a command
- cmd0  in  8  source 0 command
- clr_rdy0  out  1  one-cycle pulse; source 0 command consumed
- rdy1  in  1  source 1 has a command
- cmd1  in  8  source 1 command
- clr_rdy1  out  1  one-cycle pulse; source 1 command consumed
- cmd_rdy  out  1  command valid to command processor
- cmd  out  8  latched command to command processor
- clr_cmd_rdy  in  1  command processor consumed cmd
- gnt  out  2  one-hot current owner; 00 when idle
- timeout_err  out  1  one-cycle pulse; presented command dropped on timeout

Behaviour:
- Reset (async, rst=1): state IDLE; cmd_rdy=0, cmd=8'h00, gnt=00, clr_rdy0=clr_rdy1=0, timeout_err=0, rr pointer=0 (source 0 favoured), timer=0.
- All outputs are registered (Moore); there are no combinational paths from input to output.
- States: IDLE, PRESENT, RELEASE.
- IDLE arbitration:
  - Neither rdy set: remain in IDLE.
  - Exactly one rdy set: grant that source.
  - Both rdy set, STOP_PRI=1, exactly one of the two commands is a STOP: grant the STOP source.
  - Otherwise: grant the source named by rr.
- IDLE on grant (next edge):
  - cmd <= the winner's command.
  - gnt <= the winner's one-hot code.
  - cmd_rdy <= 1.
  - timer <= 0.
  - state <= PRESENT.
- PRESENT:
  - cmd and gnt are held stable.
  - Source rdy/cmd are ignored; the command is already latched and is never retracted, even if the source drops rdy.
  - timer increments each cycle.
  - clr_cmd_rdy=1 -> next edge: cmd_rdy <= 0, clr_rdyN <= 1 for the owner, state <= RELEASE.
  - clr_cmd_rdy=0 and timer==TIMEOUT-1 -> the same transition, plus timeout_err <= 1.
  - clr_cmd_rdy and timeout in the same cycle: the acknowledge wins and timeout_err stays 0.
- RELEASE (exactly one cycle):
  - clr_rdyN and timeout_err are high during this cycle.
  - Next edge: they clear, gnt <= 00, rr <= the other source, state <= IDLE.
- Source contract: a source deasserts rdy on the edge where it samples clr_rdyN=1. IDLE therefore never re-grants a consumed command.
- Throughput: minimum 3 cycles per command (IDLE -> PRESENT -> RELEASE).
- Latency: rdy to cmd_rdy is 1 cycle.
- Invariants:
  - cmd is never modified while cmd_rdy=1.
  - gnt is one-hot whenever state != IDLE.
- Timer width: clog2(TIMEOUT); the timer saturates, it does not wrap.

Test Plan:
- Single request: rdy0=1, cmd0=8'h75 (GO, ID 0x35) -> 1 cycle later cmd_rdy=1, cmd=8'h75, gnt=01. clr_cmd_rdy pulsed -> next cycle cmd_rdy=0, clr_rdy0=1 for exactly 1 cycle, then gnt=00.
- Round-robin: rdy0 and rdy1 held with non-STOP commands 8'h75/8'h8F and acked 1 cycle after each cmd_rdy -> grant order 0,1,0,1; never two consecutive grants to the same source.
- STOP priority: rr=0, cmd0=8'h75, cmd1=8'h0D, both rdy -> source 1 granted first, cmd=8'h0D. Repeat with STOP_PRI=0 -> source 0 granted first.
- Timeout: TIMEOUT=8, grant, clr_cmd_rdy never asserted -> cmd_rdy high exactly 8 cycles, then timeout_err and clr_rdyN pulse together for 1 cycle. Ack on cycle 8 -> no timeout_err.
- Source withdraws: rdy1 dropped 1 cycle into PRESENT with cmd1 changed -> cmd keeps its latched value until acked; clr_rdy1 still pulses.
- Reset mid-PRESENT: rst=1 asynchronously -> cmd_rdy, gnt, clr_rdyN, cmd cleared immediately. After release with rdy0/rdy1 both set -> source 0 granted first.
